// File: rtl/core_pkg.sv
// Shared core definitions: data width, reset/NOP constants and the fetch bundle
// passed across the IF/ID boundary.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_bundle_t;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold register for a fetch bundle: captures while the consumer is
// stalled, drains on release, and is dropped on flush.
module fetch_skid_buffer
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_i,
  input  logic          drain_i,
  input  logic          flush_i,
  input  fetch_bundle_t entry_i,
  output fetch_bundle_t entry_o
);

  fetch_bundle_t entry_q;

  // NOTE: only the valid bit is reset; pc/instr are qualified by it, so they
  // need no reset and stay plain data registers.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      entry_q.valid <= 1'b0;
    end else if (capture_i) begin
      entry_q.valid <= 1'b1;
      entry_q.pc    <= entry_i.pc;
      entry_q.instr <= entry_i.instr;
    end else if (drain_i) begin
      entry_q.valid <= 1'b0;
    end
  end

  assign entry_o = entry_q;

  // Upstream stops issuing while stalled, so a full entry is never overwritten.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    capture_i |-> !entry_q.valid);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, absorbs the 1-cycle imem latency and presents
// a registered (valid, pc, instr) bundle to decode with stall and redirect.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  fetch_bundle_t   out_q, out_d;

  logic [XLEN-1:0] issue_addr;
  logic            issue;
  logic            skid_capture, skid_drain;
  fetch_bundle_t   resp_bundle, skid_bundle;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    issue_addr   = redirect_valid ? align_word(redirect_pc) : fetch_pc_q;
    issue        = !rst && (redirect_valid || !stall);
    resp_bundle  = '{valid: resp_valid_q, pc: resp_pc_q,
                     instr: resp_valid_q ? imem_rdata : NOP_INSTR};
    skid_capture = stall && !redirect_valid && resp_valid_q;
    skid_drain   = !stall && !redirect_valid && skid_bundle.valid;

    fetch_pc_d   = issue ? issue_addr + 32'd4 : fetch_pc_q;
    resp_valid_d = issue;
    resp_pc_d    = issue ? issue_addr : resp_pc_q;

    out_d = out_q;
    if (redirect_valid) begin
      out_d.valid = 1'b0;
      out_d.instr = NOP_INSTR;
    end else if (!stall) begin
      // A parked response is older than anything now arriving from imem.
      out_d = skid_bundle.valid ? skid_bundle : resp_bundle;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      out_q        <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      out_q        <= out_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture_i (skid_capture),
    .drain_i   (skid_drain),
    .flush_i   (redirect_valid),
    .entry_i   (resp_bundle),
    .entry_o   (skid_bundle)
  );

  assign imem_addr = issue_addr;
  assign if_valid  = out_q.valid;
  assign if_pc     = out_q.pc;
  assign if_instr  = out_q.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the stimulus side keeps the expected
// program-order stream, the monitor checks every instruction decode accepts.
module tb_instr_fetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Instruction memory: word for the address sampled at the edge, next cycle.
  always @(posedge clk) imem_rdata <= rom(imem_addr);

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  bit          mon_en = 1'b0;
  bit          final_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: after a reset or redirect the accepted stream is
  // target, target+4, ... with 32-bit wrap.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    if (r) restart(RESET_PC_DEFAULT);
    else if (rv) restart(rp);
    top_up();
  endtask

  // Input history of the two previous cycles, as seen by the monitor.
  logic        p1_rst = 1'b1, p1_stall = 1'b0, p1_redir = 1'b0;
  logic        p2_rst = 1'b1, p2_stall = 1'b0, p2_redir = 1'b0;
  logic        p1_valid;
  logic [31:0] p1_pc, p1_instr, exp_pc;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!if_valid) check("nop_when_invalid", if_instr, NOP_INSTR_DEFAULT);

      if (p1_rst) begin
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        check("reset_pc", if_pc, 32'd0);
      end else if (p1_redir) begin
        check("redirect_bubble", {31'd0, if_valid}, 32'd0);
      end else if (p1_stall) begin
        check("hold_valid", {31'd0, if_valid}, {31'd0, p1_valid});
        check("hold_pc", if_pc, p1_pc);
        check("hold_instr", if_instr, p1_instr);
      end else if (p2_rst) begin
        check("startup_bubble", {31'd0, if_valid}, 32'd0);
      end else if (p2_redir || !p2_stall) begin
        // Something was fetched two cycles ago and decode took it last cycle.
        check("stream_no_gap", {31'd0, if_valid}, 32'd1);
      end

      if (redirect_valid)
        check("issue_addr", imem_addr, {redirect_pc[31:2], 2'b00});

      if (if_valid && !stall && !redirect_valid && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_underflow: got pc %08h expected nothing", if_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          check("stream_pc", if_pc, exp_pc);
          check("stream_instr", if_instr, rom(exp_pc));
          n_consumed++;
        end
      end

      if (final_chk)
        check("enough_consumed", {31'd0, n_consumed >= 500}, 32'd1);

      p2_rst = p1_rst; p2_stall = p1_stall; p2_redir = p1_redir;
      p1_rst = rst;    p1_stall = stall;    p1_redir = redirect_valid;
      p1_valid = if_valid; p1_pc = if_pc; p1_instr = if_instr;
    end
  end

  initial begin
    logic        r, s, rv;
    logic [31:0] rp;
    restart(RESET_PC_DEFAULT);
    top_up();

    cycle(1, 0, 0, 0);
    mon_en = 1'b1;
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);              // C0..C3; if_pc=0x8 in C4
    repeat (3) cycle(0, 1, 0, 0);              // stall with 0xC parked in skid
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0040);
    repeat (5) cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);              // fill the skid
    cycle(0, 1, 1, 32'h0000_0200);             // redirect under stall flushes it
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'hFFFF_FFF8);             // wrap FFF8, FFFC, 0000_0000
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0102);             // misaligned target -> 0x100
    repeat (3) cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);                         // reset mid-stream while stalled
    repeat (5) cycle(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) == 0);
      rv = ($urandom_range(99) < 5);
      s  = ($urandom_range(99) < 30);
      rp = $urandom;
      if ($urandom_range(9) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle(r, s, rv, rp);
    end

    cycle(0, 0, 0, 0);
    final_chk = 1'b1;
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the synchronous instruction-memory read interface. Owns the PC and drives a word address every cycle.
- Absorbs the fixed 1-cycle read latency of the instruction memory.
- Presents registered (valid, pc, instr) to the IF/ID boundary. Supports downstream stall and branch/jump redirect with flush.
- Sits between the instruction memory and the decode stage of the pipelined core.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  32  byte address to instruction memory; memory samples it each rising edge and returns the word on imem_rdata in the following cycle.
- imem_rdata  in  32  instruction word for the address sampled at the previous edge.
- stall  in  1  decode cannot accept; outputs must hold.
- redirect_valid  in  1  taken branch/jump resolved; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- if_valid  out  1  if_pc/if_instr hold a real instruction.
- if_pc  out  32  address of if_instr.
- if_instr  out  32  fetched instruction; NOP_INSTR when if_valid=0.

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, resp_valid=0, skid empty, if_valid=0, if_pc=0, if_instr=NOP_INSTR. No issue while rst=1. rst overrides all other inputs.
- Issue: imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc (combinational mux).
  - Issue occurs when rst=0 and (redirect_valid or !stall).
  - On issue, resp_valid<=1, resp_pc<=imem_addr, fetch_pc<=imem_addr+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
  - On no issue, resp_valid<=0 and fetch_pc holds.
- Response: while resp_valid=1, imem_rdata is the instruction at resp_pc.
- Output update when stall=0 and no redirect:
  - If skid is full: outputs <= skid contents; skid empties.
  - Otherwise: if_valid<=resp_valid, if_pc<=resp_pc, if_instr<=resp_valid ? imem_rdata : NOP_INSTR.
- Output update when stall=1 and no redirect:
  - Outputs hold.
  - If resp_valid=1, the arriving response is captured into skid (sk_valid, sk_pc, sk_instr).
  - Skid never overflows: issue is blocked under stall, so at most one response is in flight. Asserting a second capture is an error, checked by assertion.
- Redirect (redirect_valid=1, wins over stall):
  - if_valid<=0, if_instr<=NOP_INSTR, skid cleared, in-flight response discarded.
  - Target is issued the same cycle.
  - Latency: redirect in cycle N → target instruction on outputs with if_valid=1 in cycle N+2, provided stall=0 in N+1.
- Latency:
  - First cycle with rst=0 (C0) issues RESET_PC; if_valid=1 with if_pc=RESET_PC in C2.
  - Steady state: one instruction per cycle, consecutive PCs +4.
- Stall release: the skid entry is presented first, and issue resumes in the same cycle. The stream stays gap-free except for the single bubble inherent in the 1-cycle latency.
- No instruction is duplicated or dropped across any stall/redirect sequence.

Decomposition:
- Shared package core_pkg: XLEN=32, RESET_PC default, NOP_INSTR constant, fetch-bundle typedef {valid, pc[31:0], instr[31:0]}.
- One sub-module is natural: fetch_skid_buffer, a 1-entry hold register with capture/drain/flush controls, also reusable at other stage boundaries.

Test Plan:
- Reset then run, stall=0; bench ROM word at addr A = 32'h1000_0000 + A/4 → if_valid rises in C2. if_pc sequence 0,4,8,... with matching instr 1000_0000, 1000_0001, ...; one per cycle.
- Stall for 3 cycles while if_pc=0x8 → outputs frozen at (0x8, 1000_0002). After release: 0xC then 0x10. No gaps beyond one bubble, no duplicates. Skid captured 0xC.
- Redirect to 0x40 while streaming → if_valid=0 next cycle. Cycle N+2 shows (0x40, 1000_0010), then 0x44. Nothing from the old path appears.
- Redirect asserted with stall=1 and skid full → skid flushed; cycle N+2 shows the target instruction once stall is low.
- Redirect to 0xFFFF_FFF8, and to 0x0000_0102 (misaligned) → wrap case: sequence FFF8, FFFC, 0000_0000. Misaligned case: issued address is 0x100.
- Assert rst for one cycle mid-stream with stall=1 → next cycle if_valid=0, if_instr=NOP_INSTR, skid empty; restart from RESET_PC.
